// File: rtl/serial_pkg.sv
// serial_pkg: shared defaults and receiver state encoding for the 16-bit serial link
package serial_pkg;
  localparam int DATA_BITS_DEF = 16;
  localparam int OVERSAMPLE_DEF = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_e;
endpackage

// File: rtl/serial_sync.sv
// serial_sync: 2-flop synchroniser for an asynchronous input, resets to the idle-high level
module serial_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], async_i};
  assign sync_o = sync_q[1];
endmodule

// File: rtl/serial_receive.sv
// serial_receive: oversampled UART-style receiver, start/16 data LSB first/stop, mid-bit sampling
module serial_receive
  import serial_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int CNT_W = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 SampleTick,
  input  logic                 RxIn,
  output logic [DATA_BITS-1:0] DataOut,
  output logic                 DataValid,
  output logic                 FrameError,
  output logic                 Busy
);
  localparam int BCNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] OCNT_MID = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] OCNT_END = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);
  rx_state_e state_q, state_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic rx, mid, wrap;
  serial_sync u_sync (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .async_i(RxIn),
    .sync_o (rx)
  );
  assign mid = ocnt_q == OCNT_MID;
  assign wrap = ocnt_q == OCNT_END;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      ocnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ocnt_q  <= ocnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  always_comb begin
    state_d = state_q;
    if (SampleTick)
      case (state_q)
        IDLE:      state_d = rx ? IDLE : START;
        START:     state_d = !mid ? START : rx ? IDLE : DATA;
        DATA:      state_d = (wrap && bcnt_q == BCNT_LAST) ? STOP : DATA;
        STOP:      state_d = !wrap ? STOP : rx ? IDLE : WAIT_IDLE;
        WAIT_IDLE: state_d = rx ? IDLE : WAIT_IDLE;
        default:   state_d = IDLE;
      endcase
  end
  // Strobes and the output word are only produced by the stop-bit sample.
  always_comb begin
    ocnt_d  = ocnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (SampleTick)
      case (state_q)
        START: begin
          ocnt_d = mid ? '0 : ocnt_q + 1'b1;
          bcnt_d = '0;
        end
        DATA: begin
          ocnt_d = wrap ? '0 : ocnt_q + 1'b1;
          bcnt_d = wrap ? bcnt_q + 1'b1 : bcnt_q;
          shift_d = wrap ? {rx, shift_q[DATA_BITS-1:1]} : shift_q;
        end
        STOP: begin
          ocnt_d  = wrap ? '0 : ocnt_q + 1'b1;
          valid_d = wrap && rx;
          ferr_d  = wrap && !rx;
          data_d  = (wrap && rx) ? shift_q : data_q;
        end
        default: ocnt_d = '0;
      endcase
  end
  assign Busy = state_q != IDLE;
  assign DataOut = data_q;
  assign DataValid = valid_q;
  assign FrameError = ferr_q;
endmodule

// File: tb/tb_serial_receive.sv
// tb_serial_receive: directed scenarios for serial_receive, tick every 4 clocks, 64 clocks per bit
module tb_serial_receive;
  localparam int BITC = 64;
  logic Clock = 0, Reset = 1, SampleTick = 0, RxIn = 1;
  logic [15:0] DataOut;
  logic DataValid, FrameError, Busy;
  int vectors = 0, miscompares = 0, n_valid = 0, n_ferr = 0, tcnt = 0;
  bit both_seen = 0, busy_gap = 0;
  logic [15:0] rxq[$];

  serial_receive dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .SampleTick(SampleTick),
    .RxIn      (RxIn),
    .DataOut   (DataOut),
    .DataValid (DataValid),
    .FrameError(FrameError),
    .Busy      (Busy)
  );

  initial forever #5 Clock = ~Clock;
  initial forever begin
    @(negedge Clock);
    tcnt = tcnt + 1;
    SampleTick = (tcnt % 4 == 0);
  end
  always @(negedge Clock) begin
    if (DataValid) begin
      n_valid = n_valid + 1;
      rxq.push_back(DataOut);
    end
    if (FrameError) n_ferr = n_ferr + 1;
    if (DataValid && FrameError) both_seen = 1;
  end

  task automatic send_bit(input logic b);
    RxIn = b;
    repeat (BITC) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [15:0] w, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 16; i++) begin
      RxIn = w[i];
      repeat (BITC / 2) @(negedge Clock);
      if (Busy !== 1'b1) busy_gap = 1;
      repeat (BITC / 2) @(negedge Clock);
    end
    send_bit(stop);
  endtask

  task automatic test_reset;
    Reset = 1;
    repeat (3) @(negedge Clock);
    vectors++; if (DataOut !== 16'h0) begin miscompares++; $display("FAIL reset_dataout: got %h expected %h", DataOut, 16'h0); end
    vectors++; if (DataValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", DataValid); end
    vectors++; if (FrameError !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b expected 0", FrameError); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    Reset = 0;
    repeat (16) @(negedge Clock);
  endtask

  task automatic test_single;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr; busy_gap = 0; rxq.delete();
    send_frame(16'hA5C3, 1'b1);
    repeat (BITC) @(negedge Clock);
    vectors++; if (n_valid - v0 !== 1) begin miscompares++; $display("FAIL single_valid_count: got %0d expected 1", n_valid - v0); end
    vectors++; if (DataOut !== 16'hA5C3) begin miscompares++; $display("FAIL single_dataout: got %h expected a5c3", DataOut); end
    vectors++; if (n_ferr - f0 !== 0) begin miscompares++; $display("FAIL single_ferr_count: got %0d expected 0", n_ferr - f0); end
    vectors++; if (busy_gap !== 1'b0) begin miscompares++; $display("FAIL single_busy_mid: got gap %b expected 0", busy_gap); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_after: got %b expected 0", Busy); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got;
    got = 'x; rxq.delete();
    send_frame(16'h0001, 1'b1);
    send_frame(16'hFFFF, 1'b1);
    repeat (BITC) @(negedge Clock);
    if (rxq.size() >= 1) got[31:16] = rxq[0];
    if (rxq.size() >= 2) got[15:0] = rxq[1];
    vectors++; if (rxq.size() !== 2) begin miscompares++; $display("FAIL b2b_count: got %0d expected 2", rxq.size()); end
    vectors++; if (got[31:16] !== 16'h0001) begin miscompares++; $display("FAIL b2b_first: got %h expected 0001", got[31:16]); end
    vectors++; if (got[15:0] !== 16'hFFFF) begin miscompares++; $display("FAIL b2b_second: got %h expected ffff", got[15:0]); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    logic [15:0] prev;
    v0 = n_valid; f0 = n_ferr; prev = DataOut;
    RxIn = 0;
    repeat (12) @(negedge Clock);
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_detect: got %b expected 1", Busy); end
    RxIn = 1;
    repeat (2 * BITC) @(negedge Clock);
    vectors++; if (n_valid !== v0) begin miscompares++; $display("FAIL glitch_valid: got %0d expected %0d", n_valid, v0); end
    vectors++; if (n_ferr !== f0) begin miscompares++; $display("FAIL glitch_ferr: got %0d expected %0d", n_ferr, f0); end
    vectors++; if (DataOut !== prev) begin miscompares++; $display("FAIL glitch_dataout: got %h expected %h", DataOut, prev); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_after: got %b expected 0", Busy); end
  endtask

  task automatic test_frame_error;
    int v0, f0;
    logic [15:0] prev;
    v0 = n_valid; f0 = n_ferr; prev = DataOut;
    send_frame(16'h1234, 1'b0);
    RxIn = 0;
    repeat (40 * 4) @(negedge Clock);
    vectors++; if (n_ferr - f0 !== 1) begin miscompares++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - f0); end
    vectors++; if (n_valid !== v0) begin miscompares++; $display("FAIL ferr_no_valid: got %0d expected %0d", n_valid, v0); end
    vectors++; if (DataOut !== prev) begin miscompares++; $display("FAIL ferr_dataout: got %h expected %h", DataOut, prev); end
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL ferr_busy_break: got %b expected 1", Busy); end
    RxIn = 1;
    repeat (2 * BITC) @(negedge Clock);
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL ferr_busy_release: got %b expected 0", Busy); end
    vectors++; if (n_valid !== v0) begin miscompares++; $display("FAIL ferr_spurious_valid: got %0d expected %0d", n_valid, v0); end
    vectors++; if (n_ferr - f0 !== 1) begin miscompares++; $display("FAIL ferr_spurious_ferr: got %0d expected 1", n_ferr - f0); end
  endtask

  task automatic test_reset_mid;
    int v0, f0;
    logic [15:0] w;
    v0 = n_valid; f0 = n_ferr; w = 16'hBEEF;
    send_bit(1'b0);
    for (int i = 0; i < 7; i++) send_bit(w[i]);
    Reset = 1;
    #1;
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", Busy); end
    vectors++; if (DataOut !== 16'h0) begin miscompares++; $display("FAIL rstmid_dataout: got %h expected 0000", DataOut); end
    repeat (4) @(negedge Clock);
    Reset = 0; RxIn = 1;
    repeat (2 * BITC) @(negedge Clock);
    send_frame(16'h0F0F, 1'b1);
    repeat (BITC) @(negedge Clock);
    vectors++; if (n_valid - v0 !== 1) begin miscompares++; $display("FAIL rstmid_valid_count: got %0d expected 1", n_valid - v0); end
    vectors++; if (DataOut !== 16'h0F0F) begin miscompares++; $display("FAIL rstmid_dataout_new: got %h expected 0f0f", DataOut); end
    vectors++; if (n_ferr !== f0) begin miscompares++; $display("FAIL rstmid_ferr: got %0d expected %0d", n_ferr, f0); end
  endtask

  task automatic test_loopback;
    logic [15:0] words[8];
    logic [15:0] got;
    rxq.delete();
    foreach (words[i]) words[i] = 16'($urandom);
    foreach (words[i]) send_frame(words[i], 1'b1);
    repeat (BITC) @(negedge Clock);
    vectors++; if (rxq.size() !== 8) begin miscompares++; $display("FAIL loop_count: got %0d expected 8", rxq.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < rxq.size()) ? rxq[i] : 16'hxxxx;
      vectors++; if (got !== words[i]) begin miscompares++; $display("FAIL loop_word%0d: got %h expected %h", i, got, words[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_error;
    test_reset_mid;
    test_loopback;
    vectors++; if (both_seen !== 1'b0) begin miscompares++; $display("FAIL strobe_overlap: got %b expected 0", both_seen); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
